// File: rtl/uart_rx_word_if.sv
// Signal bundle between the word receiver and its host-side user: serial line
// and enable in, received bytes, assembled words and status out.
interface uart_rx_word_if;
    logic        rx;
    logic        rx_en;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic [31:0] data_out;
    logic        data_valid;
    logic        frame_err;
    logic        synced;

    modport master (
        output rx, rx_en,
        input  byte_out, byte_valid, data_out, data_valid, frame_err, synced
    );

    modport slave (
        input  rx, rx_en,
        output byte_out, byte_valid, data_out, data_valid, frame_err, synced
    );
endinterface

// File: rtl/uart_rx_word.sv
// UART receiver for 11-bit frames (start, 8 data LSB first, zero check slot, stop)
// that reassembles 6-byte records (4 data bytes, CR, LF) into 32-bit words.
module uart_rx_word #(
    parameter int unsigned BIT_CYC  = 868,
    parameter int unsigned HALF_CYC = 434
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_word_if.slave   bus
);

    localparam logic [9:0] BIT_LAST  = 10'(BIT_CYC - 1);
    localparam logic [9:0] HALF_LAST = 10'(HALF_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_CHK   = 3'd3,
        S_STOP  = 3'd4,
        S_BREAK = 3'd5
    } state_t;

    logic        rx_meta_q, rx_s_q, rx_prev_q;
    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [2:0]  bitn_q, bitn_d;
    logic [7:0]  shift_q, shift_d;
    logic        chk_bad_q, chk_bad_d;
    logic        byte_fire_s, bit_err_s;

    logic [7:0]  byte_out_q;
    logic        byte_valid_q, bit_err_q;

    logic [2:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [31:0] data_out_q, data_out_d;
    logic        synced_q, synced_d;
    logic        armed_q, armed_d;
    logic        data_valid_q, dv_s;
    logic        frame_err_q, rec_err_s;

    logic        fall_s;
    logic        bit_hit_s;

    assign fall_s    = rx_prev_q & ~rx_s_q;
    assign bit_hit_s = (cnt_q == BIT_LAST);

    // Two-flop synchroniser for the asynchronous line plus one delay for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Bit-level FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 10'd0;
            bitn_q    <= 3'd0;
            shift_q   <= 8'd0;
            chk_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitn_q    <= bitn_d;
            shift_q   <= shift_d;
            chk_bad_q <= chk_bad_d;
        end
    end

    // Bit-level FSM next state: mid-bit sampling of start, data, check and stop
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 10'd1;
        bitn_d      = bitn_q;
        shift_d     = shift_q;
        chk_bad_d   = chk_bad_q;
        byte_fire_s = 1'b0;
        bit_err_s   = 1'b0;
        if (!bus.rx_en) begin
            state_d = S_IDLE;
            cnt_d   = 10'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = 10'd0;
                    if (fall_s) state_d = S_START;
                    else        state_d = S_IDLE;
                end
                S_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_d     = 10'd0;
                        bitn_d    = 3'd0;
                        chk_bad_d = 1'b0;
                        if (rx_s_q) state_d = S_IDLE;
                        else        state_d = S_DATA;
                    end else begin
                        state_d = S_START;
                    end
                end
                S_DATA: begin
                    if (bit_hit_s) begin
                        cnt_d   = 10'd0;
                        shift_d = {rx_s_q, shift_q[7:1]};
                        bitn_d  = bitn_q + 3'd1;
                        if (bitn_q == 3'd7) state_d = S_CHK;
                        else                state_d = S_DATA;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_CHK: begin
                    if (bit_hit_s) begin
                        cnt_d     = 10'd0;
                        chk_bad_d = rx_s_q;
                        state_d   = S_STOP;
                    end else begin
                        state_d = S_CHK;
                    end
                end
                S_STOP: begin
                    if (bit_hit_s) begin
                        cnt_d = 10'd0;
                        if (!rx_s_q) begin
                            bit_err_s = 1'b1;
                            state_d   = S_BREAK;
                        end else if (chk_bad_q) begin
                            bit_err_s = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            byte_fire_s = 1'b1;
                            state_d     = S_IDLE;
                        end
                    end else begin
                        state_d = S_STOP;
                    end
                end
                S_BREAK: begin
                    cnt_d = 10'd0;
                    if (rx_s_q) state_d = S_IDLE;
                    else        state_d = S_BREAK;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 10'd0;
                end
            endcase
        end
    end

    // Byte output register and the bit-error event handed to the assembler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_out_q   <= 8'd0;
            byte_valid_q <= 1'b0;
            bit_err_q    <= 1'b0;
        end else begin
            byte_out_q   <= byte_fire_s ? shift_q : byte_out_q;
            byte_valid_q <= byte_fire_s;
            bit_err_q    <= bit_err_s;
        end
    end

    // Record assembler: fill word in sync, scan for CR LF while hunting
    always_comb begin
        idx_d      = idx_q;
        word_d     = word_q;
        data_out_d = data_out_q;
        synced_d   = synced_q;
        armed_d    = armed_q;
        dv_s       = 1'b0;
        rec_err_s  = 1'b0;
        if (bit_err_q) begin
            synced_d = 1'b0;
            armed_d  = 1'b0;
            idx_d    = 3'd0;
        end else if (byte_valid_q && synced_q) begin
            case (idx_q)
                3'd0: begin word_d[7:0]   = byte_out_q; idx_d = 3'd1; end
                3'd1: begin word_d[15:8]  = byte_out_q; idx_d = 3'd2; end
                3'd2: begin word_d[23:16] = byte_out_q; idx_d = 3'd3; end
                3'd3: begin word_d[31:24] = byte_out_q; idx_d = 3'd4; end
                3'd4: begin
                    if (byte_out_q == 8'h0D) begin
                        idx_d = 3'd5;
                    end else begin
                        rec_err_s = 1'b1;
                        synced_d  = 1'b0;
                        armed_d   = 1'b0;
                        idx_d     = 3'd0;
                    end
                end
                3'd5: begin
                    idx_d = 3'd0;
                    if (byte_out_q == 8'h0A) begin
                        data_out_d = word_q;
                        dv_s       = 1'b1;
                    end else begin
                        rec_err_s = 1'b1;
                        synced_d  = 1'b0;
                        armed_d   = (byte_out_q == 8'h0D);
                    end
                end
                default: idx_d = 3'd0;
            endcase
        end else if (byte_valid_q) begin
            if (armed_q && (byte_out_q == 8'h0A)) begin
                synced_d = 1'b1;
                idx_d    = 3'd0;
                armed_d  = 1'b0;
            end else begin
                armed_d = (byte_out_q == 8'h0D);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Assembler registers and the combined error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= 3'd0;
            word_q       <= 32'd0;
            data_out_q   <= 32'd0;
            synced_q     <= 1'b1;
            armed_q      <= 1'b0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            word_q       <= word_d;
            data_out_q   <= data_out_d;
            synced_q     <= synced_d;
            armed_q      <= armed_d;
            data_valid_q <= dv_s;
            frame_err_q  <= bit_err_s | rec_err_s;
        end
    end

    assign bus.byte_out   = byte_out_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.synced     = synced_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word at a shortened bit period; pulse counters are
// kept by a negedge monitor and compared against hand-computed expectations.
module tb_uart_rx_word;

    localparam int BIT  = 16;
    localparam int HALF = 8;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    int          n_byte = 0;
    int          n_data = 0;
    int          n_ferr = 0;
    logic [31:0] last_data = 32'd0;
    logic [31:0] dq[$];

    int          b0, d0, f0, q0;

    uart_rx_word_if bus ();

    uart_rx_word #(.BIT_CYC(BIT), .HALF_CYC(HALF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.byte_valid) n_byte <= n_byte + 1;
            if (bus.frame_err)  n_ferr <= n_ferr + 1;
            if (bus.data_valid) begin
                n_data    <= n_data + 1;
                last_data <= bus.data_out;
                dq.push_back(bus.data_out);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic c, input logic s);
        bus.rx = 1'b0;
        hold(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            hold(BIT);
        end
        bus.rx = c;
        hold(BIT);
        bus.rx = s;
        hold(BIT);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1);
    endtask

    task automatic send_record(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
        send_byte(8'h0D);
        send_byte(8'h0A);
    endtask

    task automatic snap();
        b0 = n_byte;
        d0 = n_data;
        f0 = n_ferr;
        q0 = dq.size();
    endtask

    initial begin
        rst       = 1'b1;
        bus.rx    = 1'b1;
        bus.rx_en = 1'b1;
        hold(4);
        chk("rst_byte_out",   {24'd0, bus.byte_out}, 32'd0);
        chk("rst_data_out",   bus.data_out, 32'd0);
        chk("rst_byte_valid", {31'd0, bus.byte_valid}, 32'd0);
        chk("rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
        chk("rst_frame_err",  {31'd0, bus.frame_err}, 32'd0);
        chk("rst_synced",     {31'd0, bus.synced}, 32'd1);
        rst = 1'b0;
        hold(BIT);

        // 1: plain record
        snap();
        send_record(32'h12345678);
        hold(BIT);
        chk("t1_bytes", n_byte - b0, 32'd6);
        chk("t1_words", n_data - d0, 32'd1);
        chk("t1_data",  last_data, 32'h12345678);
        chk("t1_ferr",  n_ferr - f0, 32'd0);
        chk("t1_last_byte", {24'd0, bus.byte_out}, 32'h0A);

        // 2: short low glitch is a false start; receiver still works afterwards
        snap();
        bus.rx = 1'b0;
        hold(HALF / 2);
        bus.rx = 1'b1;
        hold(3 * BIT);
        chk("t2_bytes", n_byte - b0, 32'd0);
        chk("t2_ferr",  n_ferr - f0, 32'd0);
        send_record(32'hCAFE0001);
        hold(BIT);
        chk("t2_data", last_data, 32'hCAFE0001);

        // 3: bad check slot, then resync and a record
        snap();
        send_frame(8'h55, 1'b1, 1'b1);
        hold(BIT);
        chk("t3_ferr",   n_ferr - f0, 32'd1);
        chk("t3_bytes",  n_byte - b0, 32'd0);
        chk("t3_unsync", {31'd0, bus.synced}, 32'd0);
        send_byte(8'h0D);
        send_byte(8'h0A);
        hold(BIT);
        chk("t3_resync", {31'd0, bus.synced}, 32'd1);
        chk("t3_no_word", n_data - d0, 32'd0);
        send_record(32'hDEADBEEF);
        hold(BIT);
        chk("t3_words", n_data - d0, 32'd1);
        chk("t3_data",  last_data, 32'hDEADBEEF);

        // 4: wrong terminator, hunt, then record
        snap();
        send_byte(8'h44); send_byte(8'h33); send_byte(8'h22);
        send_byte(8'h11); send_byte(8'h0E); send_byte(8'h0A);
        hold(BIT);
        chk("t4_ferr",   n_ferr - f0, 32'd1);
        chk("t4_words",  n_data - d0, 32'd0);
        chk("t4_unsync", {31'd0, bus.synced}, 32'd0);
        send_byte(8'h0D);
        send_byte(8'h0A);
        send_record(32'h80000001);
        hold(BIT);
        chk("t4_words2", n_data - d0, 32'd1);
        chk("t4_data",   last_data, 32'h80000001);
        chk("t4_synced", {31'd0, bus.synced}, 32'd1);

        // 5: back-to-back records with single stop bits
        snap();
        send_record(32'h00000000);
        send_record(32'hFFFFFFFF);
        hold(BIT);
        chk("t5_words", dq.size() - q0, 32'd2);
        chk("t5_first",  dq[q0],     32'h00000000);
        chk("t5_second", dq[q0 + 1], 32'hFFFFFFFF);
        chk("t5_ferr",   n_ferr - f0, 32'd0);

        // 6a: reset in the middle of byte 2 of a record
        snap();
        send_byte(8'h11);
        send_byte(8'h22);
        bus.rx = 1'b0;
        hold(BIT);
        bus.rx = 1'b1;
        hold(2 * BIT);
        rst = 1'b1;
        hold(3);
        bus.rx = 1'b1;
        chk("t6_rst_data",   bus.data_out, 32'd0);
        chk("t6_rst_synced", {31'd0, bus.synced}, 32'd1);
        rst = 1'b0;
        hold(2 * BIT);
        chk("t6_bytes_before", n_byte - b0, 32'd2);
        chk("t6_no_word",      n_data - d0, 32'd0);
        send_record(32'h0000ABCD);
        hold(BIT);
        chk("t6_words", n_data - d0, 32'd1);
        chk("t6_data",  last_data, 32'h0000ABCD);
        chk("t6_ferr",  n_ferr - f0, 32'd0);

        // 6b: line held low through the stop bit
        snap();
        send_frame(8'h5A, 1'b0, 1'b0);
        hold(5 * BIT);
        chk("t6_brk_ferr",   n_ferr - f0, 32'd1);
        chk("t6_brk_bytes",  n_byte - b0, 32'd0);
        chk("t6_brk_unsync", {31'd0, bus.synced}, 32'd0);
        bus.rx = 1'b1;
        hold(2 * BIT);
        send_byte(8'h0D);
        send_byte(8'h0A);
        hold(BIT);
        chk("t6_brk_recover", n_byte - b0, 32'd2);
        chk("t6_brk_synced",  {31'd0, bus.synced}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
